// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over a valid/ready handshake and
// sends it one bit per clock, framed by serial_valid/serial_last, with an optional idle gap.
module piso_serial_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last,
  output logic             busy
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);
  localparam bit             HasGap  = (GAP_CYCLES != 0);
  localparam logic [7:0]     GapLast = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [7:0]       gap_cnt_q;

  logic             load_bit;
  logic             shift_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;
  logic [CntW-1:0]  bit_cnt_inc;
  logic             at_last;
  logic             start;

  // The first bit goes straight to serial_out, so the shift register holds only what remains.
  always_comb begin
    load_bit    = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
    shift_bit   = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
    load_rest   = LSB_FIRST ? (load_data >> 1) : (load_data << 1);
    shift_rest  = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
    bit_cnt_inc = bit_cnt_q + CntW'(1);
    at_last     = (bit_cnt_q == LastIdx);
    start       = load_valid && load_ready &&
                  ((state_q == StIdle) || ((state_q == StShift) && at_last && !HasGap));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      load_ready   <= 1'b1;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      serial_last  <= 1'b0;
      busy         <= 1'b0;
    end else if (start) begin
      state_q      <= StShift;
      shift_q      <= load_rest;
      bit_cnt_q    <= '0;
      load_ready   <= 1'b0;
      serial_out   <= load_bit;
      serial_valid <= 1'b1;
      serial_last  <= 1'b0;
      busy         <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          load_ready <= 1'b1;
          busy       <= 1'b0;
        end
        StShift: begin
          if (at_last) begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
            bit_cnt_q    <= '0;
            if (HasGap) begin
              state_q    <= StGap;
              gap_cnt_q  <= '0;
              load_ready <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state_q    <= StIdle;
              load_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end else begin
            bit_cnt_q   <= bit_cnt_inc;
            shift_q     <= shift_rest;
            serial_out  <= shift_bit;
            serial_last <= (bit_cnt_inc == LastIdx);
            // Back-to-back loading is only offered when no gap follows the word.
            load_ready  <= !HasGap && (bit_cnt_inc == LastIdx);
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q    <= StIdle;
            gap_cnt_q  <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q      <= StIdle;
          load_ready   <= 1'b1;
          serial_valid <= 1'b0;
          serial_out   <= 1'b0;
          serial_last  <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
